mux_scan_sel: RTL

//   Parametrised N-channel, W-bit registered selector. Successor to the fixed 8:1 bit mux.
//   Two selection modes:
//     - manual: channel loaded from sel_in.
//     - auto-scan: channel rotates round-robin, holding each for DWELL accepted samples.

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/scan_sel_ctr.sv | 69 ++++++
 rtl/mux_scan_sel.sv | 63 ++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared mode encodings and width helpers for the scan selector.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // $clog2 that never collapses to zero, so 1-channel or 1-deep builds still get a 1-bit field
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
        return r;
    endfunction

endpackage

// File: rtl/scan_sel_ctr.sv
// Channel pointer for the scan selector: manual load, round-robin dwell advance, sticky bad-load flag.
module scan_sel_ctr
    import mux_scan_pkg::*;
#(
    parameter int unsigned NCH   = 8,
    parameter int unsigned DWELL = 4,
    parameter int unsigned SELW  = clog2_min1(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            load,
    input  logic [SELW-1:0] sel_in,
    input  logic            hs,
    output logic [SELW-1:0] cur_sel,
    output logic            sel_err
);

    localparam int unsigned     DCW        = clog2_min1(DWELL);
    localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [SELW-1:0] SEL_LAST   = SELW'(NCH - 1);

    logic [DCW-1:0]  dwell_cnt;
    logic [DCW-1:0]  dwell_nxt;
    logic [SELW-1:0] sel_nxt;
    logic            err_nxt;
    logic            mode_q;
    logic            sel_ok;

    assign sel_ok = (32'(sel_in) < NCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel   <= '0;
            dwell_cnt <= '0;
            sel_err   <= 1'b0;
            mode_q    <= MODE_MANUAL;
        end else begin
            cur_sel   <= sel_nxt;
            dwell_cnt <= dwell_nxt;
            sel_err   <= err_nxt;
            mode_q    <= mode;
        end
    end

    // Priority: valid load, then mode change / manual hold, then scan advance on handshake
    always_comb begin
        sel_nxt   = cur_sel;
        dwell_nxt = dwell_cnt;
        err_nxt   = sel_err;
        if (load && !sel_ok) begin
            err_nxt = 1'b1;
        end
        if (load && sel_ok) begin
            sel_nxt   = sel_in;
            dwell_nxt = '0;
        end else if ((mode != mode_q) || (mode == MODE_MANUAL)) begin
            dwell_nxt = '0;
        end else if (hs) begin
            if (dwell_cnt == DWELL_LAST) begin
                dwell_nxt = '0;
                sel_nxt   = (cur_sel == SEL_LAST) ? '0 : cur_sel + SELW'(1);
            end else begin
                dwell_nxt = dwell_cnt + DCW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// N-channel W-bit registered selector with manual/auto-scan channel choice and a valid/ready output stage.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int unsigned NCH   = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned DWELL = 4,
    parameter int unsigned SELW  = clog2_min1(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [SELW-1:0]  sel_in,
    input  logic [NCH*W-1:0] din,
    output logic [W-1:0]     dout,
    output logic [SELW-1:0]  dout_ch,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             sel_err
);

    logic [NCH-1:0][W-1:0] chan_c;
    logic [SELW-1:0]       cur_sel;
    logic                  hs_c;
    logic                  cap_c;

    assign chan_c = din;
    assign hs_c   = dout_vld && dout_rdy;
    assign cap_c  = en && (!dout_vld || dout_rdy);

    scan_sel_ctr #(
        .NCH   (NCH),
        .DWELL (DWELL),
        .SELW  (SELW)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .load    (load),
        .sel_in  (sel_in),
        .hs      (hs_c),
        .cur_sel (cur_sel),
        .sel_err (sel_err)
    );

    // Output register: capture when the slot is free or being drained, else drop valid on a final accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_ch  <= '0;
            dout_vld <= 1'b0;
        end else if (cap_c) begin
            dout     <= chan_c[cur_sel];
            dout_ch  <= cur_sel;
            dout_vld <= 1'b1;
        end else if (hs_c) begin
            dout_vld <= 1'b0;
        end
    end

endmodule
